// File: rtl/product_accumulator_pkg.sv
// Shared defaults, derived widths and state encoding for the product accumulator.
package product_accumulator_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int GUARD_DEF  = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int PROD_W_DEF = 2 * WIDTH_DEF;
  localparam int ACC_W_DEF  = PROD_W_DEF + GUARD_DEF;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums unsigned product beats into one result per in_last; result valid 1 cycle after the last beat.
// Backpressure: in_ready drops while a result is held; in_ready returns the cycle after out_ready handoff.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [2*WIDTH-1:0]         in_prod,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH+GUARD-1:0]   out_sum,
  output logic                       out_ovf,
  output logic [CNT_W-1:0]           out_count
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + GUARD;

  state_t           state;
  logic [AW-1:0]    acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic [AW:0]      sum_ext;
  logic             accept;
  logic             handoff;

  assign accept  = in_valid & in_ready;
  assign handoff = out_valid & out_ready;

  // acc is zero after reset/handoff, so the first beat's add is effectively a load
  always_comb begin
    sum_ext = {1'b0, acc} + {{(GUARD + 1){1'b0}}, in_prod};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept && in_last) begin
            state     <= HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (handoff) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum_ext[AW-1:0];
      ovf <= ovf | sum_ext[AW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (handoff) begin
      cnt <= '0;
    end else if (accept && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed, table-driven bench for product_accumulator with hand-written corner sequences.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.WIDTH(16), .GUARD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic        last;
    logic [39:0] exp_sum;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    chk({name, " out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic chk_result(input string name, input logic [39:0] s, input logic [7:0] c,
                            input logic o);
    chk({name, " out_valid"}, 64'(out_valid), 64'd1);
    chk({name, " in_ready"}, 64'(in_ready), 64'd0);
    chk({name, " out_sum"}, 64'(out_sum), 64'(s));
    chk({name, " out_count"}, 64'(out_count), 64'(c));
    chk({name, " out_ovf"}, 64'(out_ovf), 64'(o));
  endtask

  logic [39:0] held_sum;

  initial begin
    vecs[0] = '{32'd3,          1'b0, 40'd0,          8'd0};
    vecs[1] = '{32'd5,          1'b0, 40'd0,          8'd0};
    vecs[2] = '{32'd7,          1'b1, 40'd15,         8'd3};
    vecs[3] = '{32'hFFFE0001,   1'b1, 40'hFFFE0001,   8'd1};
    vecs[4] = '{32'd2,          1'b0, 40'd0,          8'd0};
    vecs[5] = '{32'd2,          1'b1, 40'd4,          8'd2};

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset out_sum", 64'(out_sum), 64'd0);
    chk("reset out_count", 64'(out_count), 64'd0);
    chk("reset out_ovf", 64'(out_ovf), 64'd0);
    #5 rst = 1'b0;
    tick();
    chk_idle("post-reset");

    // 257 max-magnitude beats: carry out of 40 bits, counter saturates
    for (int i = 1; i <= 257; i++) begin
      in_valid = 1'b1; in_prod = 32'hFFFE0001; in_last = (i == 257);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk_result("sat257", 40'h00FDFE0101, 8'd255, 1'b1);
    out_ready = 1'b1;
    tick();
    chk_idle("sat257 handoff");

    // Table: out_ready held high throughout, in_ready low exactly one cycle per result
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_prod = vecs[i].prod; in_last = vecs[i].last;
      tick();
      if (vecs[i].last) begin
        in_valid = 1'b0; in_last = 1'b0;
        chk_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cnt, 1'b0);
        tick();
        chk_idle($sformatf("vec%0d handoff", i));
      end else begin
        chk_idle($sformatf("vec%0d accum", i));
      end
    end
    // Back-to-back single-beat result following the 2+2 result
    in_valid = 1'b1; in_prod = 32'd4; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk_result("b2b single", 40'd4, 8'd1, 1'b0);
    tick();
    chk_idle("b2b handoff");

    // Stall in HOLD for 10 cycles while upstream keeps presenting beats
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 32'd10; in_last = 1'b1;
    tick();
    held_sum = out_sum;
    chk("stall first sum", 64'(held_sum), 64'd10);
    in_prod = 32'd99;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall%0d out_sum", i), 64'(out_sum), 64'(held_sum));
      chk($sformatf("stall%0d out_count", i), 64'(out_count), 64'd1);
      chk($sformatf("stall%0d out_valid", i), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    chk_idle("stall handoff");
    tick();
    chk_result("after stall", 40'd99, 8'd1, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk_idle("after stall handoff");

    // Reset mid-accumulation: partial sum discarded, outputs clear immediately
    in_valid = 1'b1; in_prod = 32'd5; in_last = 1'b0;
    tick();
    in_prod = 32'd6;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_idle("midrst");
    chk("midrst out_sum", 64'(out_sum), 64'd0);
    chk("midrst out_count", 64'(out_count), 64'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst quiet%0d out_valid", i), 64'(out_valid), 64'd0);
    end
    in_valid = 1'b1; in_prod = 32'd8; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk_result("midrst next", 40'd8, 8'd1, 1'b0);

    // Reset while holding a result: pending result dropped
    out_ready = 1'b0;
    tick();
    chk("hold stays", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle("holdrst");
    chk("holdrst out_sum", 64'(out_sum), 64'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk_idle("holdrst after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the multiplier operand width.
REQ-002 SHALL have parameter GUARD, default 8, the extra accumulator bits above the 2*WIDTH product.
REQ-003 SHALL have parameter CNT_W, default 8, the term-counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, product beat present, aligned by the integrator with the multiplier's fixed latency.
REQ-007 SHALL have port in_prod, input, 2*WIDTH, unsigned product from the upstream multiplier.
REQ-008 SHALL have port in_last, input, 1, marks the final term of a dot product; qualified by in_valid.
REQ-009 SHALL have port in_ready, output, 1, the accumulator accepts a beat this cycle.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port out_sum, output, 2*WIDTH+GUARD, the accumulated sum.
REQ-013 SHALL have port out_ovf, output, 1, sticky overflow of out_sum for this result.
REQ-014 SHALL have port out_count, output, CNT_W, number of terms accepted for this result (saturating).

Function
REQ-015 SHALL implement FSM states ACC and HOLD; reset state ACC.
REQ-016 In ACC: in_ready=1, out_valid=0; in HOLD: in_ready=0, out_valid=1.
REQ-017 Beat accepted when in_valid & in_ready; the first beat after reset or after a result handoff loads acc=in_prod, and each later beat sets acc=acc+in_prod.
REQ-018 Addition SHALL be unsigned modulo 2^(2*WIDTH+GUARD); a carry-out SHALL set the sticky ovf flag for the current result.
REQ-019 Term counter SHALL increment per accepted beat and saturate at 2^CNT_W-1, with no wrap.
REQ-020 Accepted beat with in_last=1: ACC->HOLD; out_sum/out_ovf/out_count reflect that beat at the next edge (latency 1 cycle from last beat to out_valid).
REQ-021 In HOLD, out_sum/out_ovf/out_count SHALL be stable until handoff (out_valid & out_ready).
REQ-022 On handoff: HOLD->ACC; acc, ovf and count are cleared; in_ready rises the following cycle (no same-cycle bypass).
REQ-023 in_valid while in HOLD SHALL be ignored; the upstream SHALL hold or drop it (integrator responsibility).
REQ-024 A single-beat result (in_last on the first beat) SHALL give out_sum=in_prod, out_count=1.
REQ-025 out_ready while in ACC SHALL have no effect.

Reset
REQ-026 rst SHALL asynchronously force state=ACC, acc=0, ovf=0, count=0, out_valid=0, in_ready=1, out_sum=0, out_ovf=0, out_count=0.
REQ-027 Reset mid-accumulation or in HOLD SHALL discard the partial or pending result with no output beat.
REQ-028 Release of rst SHALL be followed by normal operation from the first clk edge after deassertion.

Structure
REQ-029 A shared package SHALL hold the WIDTH/GUARD/CNT_W defaults, the derived product width 2*WIDTH and accumulator width 2*WIDTH+GUARD, and the state encoding ACC=0, HOLD=1.
REQ-030 No sub-module is required; a single flat module with separate FSM, datapath and counter processes is the structure.

Verification
REQ-031 rst pulse mid-stream -> all outputs at reset values within the same cycle; no out_valid afterwards until a new in_last.
REQ-032 Beats 3, 5, 7 (last on 7), out_ready=1 -> one cycle after the 7 beat, out_sum=15, out_count=3, out_ovf=0; in_ready=0 for exactly one cycle.
REQ-033 Single beat 0xFFFE0001 with last -> out_sum=0xFFFE0001, out_count=1.
REQ-034 257 beats of 0xFFFE0001 (WIDTH=16, GUARD=8) -> out_ovf=1, out_count=255 (saturated), out_sum = 257*0xFFFE0001 mod 2^40.
REQ-035 out_ready held 0 for 10 cycles in HOLD while in_valid=1 -> out_sum stable and no beats accepted; after out_ready=1, the next result starts clean (count=1 on its first beat).
REQ-036 Back-to-back results 2+2 (last) then 4 (last) -> outputs 4 then 4, each with the correct count (2 then 1), no carry-over of ovf.
